// File: rtl/decode_redirect_stage.sv
// ---------------------------------------------------------------------------
// decode_redirect_stage
//
// Instruction-decode stage. It takes the IF/ID pair (instruction, PC+4),
// resolves beq/bne/j/jal/jr in ID and drives the fetch-side PC controls. Fetch
// cannot stall or flush, so hazards are handled differently:
//   - The hazarding instruction is replayed through the jump path
//     (jumpTarget = PC+4-4).
//   - Whatever fetch delivers in the cycle after any redirect is squashed.
// The ID/EX pipeline word toward execute is registered here.
//
// Ports
//   Clk, Reset          clock, asynchronous active-low reset
//   Instruction_in      instruction from IF/ID
//   PCAddResult_in      PC+4 of Instruction_in
//   ReadReg1/ReadReg2   rs/rt fields to the register file (combinational)
//   ReadData1/ReadData2 register-file data for rs/rt
//   EX_MemRead, EX_RegWrite, EX_WriteReg   state of the EX instruction
//   MEM_MemRead, MEM_WriteReg              state of the MEM instruction
//   PCSrc               1 = fetch takes branchTarget
//   sel                 00 PC+4, 01 jumpTarget, 10 jrTarget
//   branchTarget        PC+4 + (sext(imm16) << 2)
//   jumpTarget          jump address, or replay address on a hazard
//   jrTarget            ReadData1
//   IDEX_*              registered ID/EX word; IDEX_Valid=0 marks a bubble
// ---------------------------------------------------------------------------
module decode_redirect_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [4:0]  LINK_REG  = 5'd31
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instruction_in,
  input  logic [31:0] PCAddResult_in,
  output logic [4:0]  ReadReg1,
  output logic [4:0]  ReadReg2,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic        EX_MemRead,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_WriteReg,
  input  logic        MEM_MemRead,
  input  logic [4:0]  MEM_WriteReg,
  output logic        PCSrc,
  output logic [1:0]  sel,
  output logic [31:0] branchTarget,
  output logic [31:0] jumpTarget,
  output logic [31:0] jrTarget,
  output logic [31:0] IDEX_Instruction,
  output logic [31:0] IDEX_PCAddResult,
  output logic [4:0]  IDEX_WriteReg,
  output logic        IDEX_Valid
);

  typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

  localparam logic [1:0] SEL_PC4 = 2'b00;
  localparam logic [1:0] SEL_JMP = 2'b01;
  localparam logic [1:0] SEL_JR  = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Sign-extended word offset of a 16-bit branch immediate.
  function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
    logic signed [31:0] ext;
    ext = signed'({{16{imm[15]}}, imm});
    return ext <<< 2;
  endfunction

  // Register 0 is hardwired, so it can never carry a dependence.
  function automatic logic reg_hit(input logic en, input logic [4:0] src,
                                   input logic [4:0] dst);
    return en && (src != 5'd0) && (src == dst);
  endfunction

  state_t state_q, state_d;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic        is_rtype, is_jr, is_beq, is_bne, is_branch, is_j, is_jal;
  logic        is_load, is_store, is_alui;
  logic        uses_rs, uses_rt, is_cmp;
  logic        run, haz_a, haz_b, haz_c, hazard, taken, redirect;
  logic [31:0] jump_addr;

  logic [31:0] idex_instr_p0, idex_pc_p0;
  logic [4:0]  idex_wr_p0;
  logic        vld_p0;

  assign opcode = Instruction_in[31:26];
  assign rs     = Instruction_in[25:21];
  assign rt     = Instruction_in[20:16];
  assign rd     = Instruction_in[15:11];
  assign funct  = Instruction_in[5:0];

  assign ReadReg1 = rs;
  assign ReadReg2 = rt;

  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_jr     = is_rtype && (funct == FN_JR);
  assign is_beq    = (opcode == OP_BEQ);
  assign is_bne    = (opcode == OP_BNE);
  assign is_branch = is_beq || is_bne;
  assign is_j      = (opcode == OP_J);
  assign is_jal    = (opcode == OP_JAL);
  assign is_load   = (opcode[5:3] == 3'b100);
  assign is_store  = (opcode[5:3] == 3'b101);
  assign is_alui   = (opcode[5:3] == 3'b001);

  // Operand classes: lui has no source register, jr reads only rs, stores
  // read rt as the store data.
  assign uses_rs = is_rtype || is_branch || is_load || is_store ||
                   (is_alui && (opcode != OP_LUI));
  assign uses_rt = (is_rtype && !is_jr) || is_branch || is_store;
  assign is_cmp  = is_branch || is_jr;

  // Decode and hazard checks only act in RUN and out of reset.
  assign run = (state_q == RUN) && Reset;

  assign haz_a = EX_MemRead &&
                 (reg_hit(uses_rs, rs, EX_WriteReg) || reg_hit(uses_rt, rt, EX_WriteReg));
  assign haz_b = EX_RegWrite &&
                 (reg_hit(is_cmp, rs, EX_WriteReg) || reg_hit(is_branch, rt, EX_WriteReg));
  assign haz_c = MEM_MemRead &&
                 (reg_hit(is_cmp, rs, MEM_WriteReg) || reg_hit(is_branch, rt, MEM_WriteReg));
  assign hazard = run && (haz_a || haz_b || haz_c);

  assign taken = (is_beq && (ReadData1 == ReadData2)) ||
                 (is_bne && (ReadData1 != ReadData2));

  assign branchTarget = PCAddResult_in + unsigned'(branch_offset(Instruction_in[15:0]));
  assign jrTarget     = ReadData1;
  assign jump_addr    = {PCAddResult_in[31:28], Instruction_in[25:0], 2'b00};

  always_comb begin
    PCSrc      = 1'b0;
    sel        = SEL_PC4;
    jumpTarget = jump_addr;
    redirect   = 1'b0;
    if (hazard) begin
      sel        = SEL_JMP;
      jumpTarget = PCAddResult_in - 32'd4;
      redirect   = 1'b1;
    end else if (run && taken) begin
      PCSrc    = 1'b1;
      redirect = 1'b1;
    end else if (run && (is_j || is_jal)) begin
      sel      = SEL_JMP;
      redirect = 1'b1;
    end else if (run && is_jr) begin
      sel      = SEL_JR;
      redirect = 1'b1;
    end
  end

  // The arrival right after any redirect is wrong-path; SQUASH covers exactly it.
  always_comb begin
    state_d = RUN;
    if ((state_q == RUN) && redirect) state_d = SQUASH;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    idex_instr_p0 = NOP_INSTR;
    idex_pc_p0    = 32'd0;
    idex_wr_p0    = 5'd0;
    vld_p0        = 1'b0;
    if (run && !hazard) begin
      idex_instr_p0 = Instruction_in;
      idex_pc_p0    = PCAddResult_in;
      vld_p0        = 1'b1;
      if (is_jal)                  idex_wr_p0 = LINK_REG;
      else if (is_rtype)           idex_wr_p0 = rd;
      else if (is_load || is_alui) idex_wr_p0 = rt;
    end
  end

  // ---- ID/EX stage boundary ----
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      IDEX_Instruction <= NOP_INSTR;
      IDEX_PCAddResult <= 32'd0;
      IDEX_WriteReg    <= 5'd0;
      IDEX_Valid       <= 1'b0;
    end else begin
      IDEX_Instruction <= idex_instr_p0;
      IDEX_PCAddResult <= idex_pc_p0;
      IDEX_WriteReg    <= idex_wr_p0;
      IDEX_Valid       <= vld_p0;
    end
  end

endmodule

// File: tb/tb_decode_redirect_stage.sv
module tb_decode_redirect_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Instruction_in, PCAddResult_in, ReadData1, ReadData2;
  logic [4:0]  ReadReg1, ReadReg2;
  logic        EX_MemRead, EX_RegWrite, MEM_MemRead;
  logic [4:0]  EX_WriteReg, MEM_WriteReg;
  logic        PCSrc;
  logic [1:0]  sel;
  logic [31:0] branchTarget, jumpTarget, jrTarget;
  logic [31:0] IDEX_Instruction, IDEX_PCAddResult;
  logic [4:0]  IDEX_WriteReg;
  logic        IDEX_Valid;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] ADD_123 = 32'h0043_0820; // add $1,$2,$3
  localparam logic [31:0] BEQ_M2  = 32'h1022_FFFE; // beq $1,$2,-2
  localparam logic [31:0] J_40    = 32'h0800_0040; // j   0x40
  localparam logic [31:0] JAL_40  = 32'h0C00_0040; // jal 0x40
  localparam logic [31:0] JR_5    = 32'h00A0_0008; // jr  $5
  localparam logic [31:0] ADD_980 = 32'h0100_4820; // add $9,$8,$0

  decode_redirect_stage dut (
    .Clk(Clk), .Reset(Reset),
    .Instruction_in(Instruction_in), .PCAddResult_in(PCAddResult_in),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
    .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg),
    .PCSrc(PCSrc), .sel(sel),
    .branchTarget(branchTarget), .jumpTarget(jumpTarget), .jrTarget(jrTarget),
    .IDEX_Instruction(IDEX_Instruction), .IDEX_PCAddResult(IDEX_PCAddResult),
    .IDEX_WriteReg(IDEX_WriteReg), .IDEX_Valid(IDEX_Valid)
  );

  always #5 Clk = ~Clk;

  // Drive one cycle's inputs at the falling edge; combinational outputs are
  // then checked 1ns later, registered outputs 1ns after the next rising edge.
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc4,
                       input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic exmr, input logic exrw, input logic [4:0] exwr,
                       input logic memmr, input logic [4:0] memwr);
    @(negedge Clk);
    Instruction_in = instr; PCAddResult_in = pc4;
    ReadData1 = rd1; ReadData2 = rd2;
    EX_MemRead = exmr; EX_RegWrite = exrw; EX_WriteReg = exwr;
    MEM_MemRead = memmr; MEM_WriteReg = memwr;
    #1;
  endtask

  task automatic after_edge();
    @(posedge Clk); #1;
  endtask

  task automatic idle2();
    drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); after_edge();
    drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); after_edge();
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Instruction_in = J_40; PCAddResult_in = 32'h3000_0010;
    ReadData1 = 0; ReadData2 = 0;
    EX_MemRead = 0; EX_RegWrite = 0; EX_WriteReg = 0; MEM_MemRead = 0; MEM_WriteReg = 0;
    #3;
    total++; if (IDEX_Valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", IDEX_Valid); end
    total++; if (IDEX_Instruction !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", IDEX_Instruction); end
    total++; if (IDEX_PCAddResult !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", IDEX_PCAddResult); end
    total++; if (IDEX_WriteReg !== 5'd0) begin bad++; $display("FAIL rst_wr got=%0d exp=0", IDEX_WriteReg); end
    total++; if (sel !== 2'b00) begin bad++; $display("FAIL rst_sel got=%b exp=00", sel); end
    total++; if (PCSrc !== 1'b0) begin bad++; $display("FAIL rst_pcsrc got=%b exp=0", PCSrc); end
    @(negedge Clk); Reset = 1'b1;
    idle2();
  endtask

  task automatic test_branch();
    drive(BEQ_M2, 32'h200, 32'd5, 32'd5, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    total++; if (PCSrc !== 1'b1) begin bad++; $display("FAIL beq_pcsrc got=%b exp=1", PCSrc); end
    total++; if (branchTarget !== 32'h1F8) begin bad++; $display("FAIL beq_target got=%h exp=1f8", branchTarget); end
    total++; if (sel !== 2'b00) begin bad++; $display("FAIL beq_sel got=%b exp=00", sel); end
    total++; if (ReadReg1 !== 5'd1 || ReadReg2 !== 5'd2) begin bad++; $display("FAIL beq_readreg got=%0d,%0d exp=1,2", ReadReg1, ReadReg2); end
    after_edge();
    total++; if (IDEX_Valid !== 1'b1 || IDEX_Instruction !== BEQ_M2) begin bad++; $display("FAIL beq_idex got=%b/%h exp=1/%h", IDEX_Valid, IDEX_Instruction, BEQ_M2); end
    // wrong-path arrival
    drive(ADD_123, 32'h204, 32'd5, 32'd5, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    total++; if (sel !== 2'b00 || PCSrc !== 1'b0) begin bad++; $display("FAIL sq_redirect got=%b/%b exp=00/0", sel, PCSrc); end
    after_edge();
    total++; if (IDEX_Valid !== 1'b0 || IDEX_Instruction !== 32'h0) begin bad++; $display("FAIL sq_bubble got=%b/%h exp=0/0", IDEX_Valid, IDEX_Instruction); end
    // not-taken
    drive(BEQ_M2, 32'h200, 32'd5, 32'd6, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    total++; if (PCSrc !== 1'b0 || sel !== 2'b00) begin bad++; $display("FAIL nt_redirect got=%b/%b exp=0/00", PCSrc, sel); end
    after_edge();
    drive(ADD_123, 32'h204, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    after_edge();
    total++; if (IDEX_Valid !== 1'b1 || IDEX_PCAddResult !== 32'h204 || IDEX_WriteReg !== 5'd1) begin
      bad++; $display("FAIL nt_nosquash got=%b/%h/%0d exp=1/204/1", IDEX_Valid, IDEX_PCAddResult, IDEX_WriteReg); end
  endtask

  task automatic test_jump();
    idle2();
    drive(J_40, 32'h3000_0010, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    total++; if (sel !== 2'b01) begin bad++; $display("FAIL j_sel got=%b exp=01", sel); end
    total++; if (jumpTarget !== 32'h3000_0100) begin bad++; $display("FAIL j_target got=%h exp=30000100", jumpTarget); end
    after_edge();
    total++; if (IDEX_Valid !== 1'b1 || IDEX_WriteReg !== 5'd0) begin bad++; $display("FAIL j_idex got=%b/%0d exp=1/0", IDEX_Valid, IDEX_WriteReg); end
    drive(ADD_123, 32'h3000_0014, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    after_edge();
    drive(JAL_40, 32'h3000_0010, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    total++; if (sel !== 2'b01 || jumpTarget !== 32'h3000_0100) begin bad++; $display("FAIL jal_redirect got=%b/%h exp=01/30000100", sel, jumpTarget); end
    after_edge();
    total++; if (IDEX_Valid !== 1'b1 || IDEX_WriteReg !== 5'd31) begin bad++; $display("FAIL jal_link got=%b/%0d exp=1/31", IDEX_Valid, IDEX_WriteReg); end
    drive(ADD_123, 32'h3000_0014, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    after_edge();
  endtask

  task automatic test_jr_hazard();
    idle2();
    drive(JR_5, 32'h500, 32'h400, 32'd0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
    total++; if (sel !== 2'b01 || PCSrc !== 1'b0) begin bad++; $display("FAIL jrhaz_sel got=%b/%b exp=01/0", sel, PCSrc); end
    total++; if (jumpTarget !== 32'h4FC) begin bad++; $display("FAIL jrhaz_replay got=%h exp=4fc", jumpTarget); end
    after_edge();
    total++; if (IDEX_Valid !== 1'b0 || IDEX_Instruction !== 32'h0) begin bad++; $display("FAIL jrhaz_bubble got=%b/%h exp=0/0", IDEX_Valid, IDEX_Instruction); end
    drive(JR_5, 32'h504, 32'h400, 32'd0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
    total++; if (sel !== 2'b00) begin bad++; $display("FAIL jrhaz_squash got=%b exp=00", sel); end
    after_edge();
    drive(JR_5, 32'h500, 32'h400, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    total++; if (sel !== 2'b10 || jrTarget !== 32'h400) begin bad++; $display("FAIL jr_replayed got=%b/%h exp=10/400", sel, jrTarget); end
    after_edge();
    total++; if (IDEX_Valid !== 1'b1) begin bad++; $display("FAIL jr_valid got=%b exp=1", IDEX_Valid); end
    // MEM-stage load feeding the jr operand also replays
    drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    after_edge();
    drive(JR_5, 32'h500, 32'h400, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5);
    total++; if (sel !== 2'b01 || jumpTarget !== 32'h4FC) begin bad++; $display("FAIL jrmem_replay got=%b/%h exp=01/4fc", sel, jumpTarget); end
    after_edge();
    drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    after_edge();
  endtask

  task automatic test_load_use();
    idle2();
    drive(ADD_980, 32'h600, 32'd0, 32'd0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
    total++; if (sel !== 2'b01 || jumpTarget !== 32'h5FC) begin bad++; $display("FAIL lu_replay got=%b/%h exp=01/5fc", sel, jumpTarget); end
    after_edge();
    total++; if (IDEX_Valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%b exp=0", IDEX_Valid); end
    drive(ADD_980, 32'h604, 32'd0, 32'd0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
    after_edge();
    drive(ADD_980, 32'h600, 32'd0, 32'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0);
    total++; if (sel !== 2'b00) begin bad++; $display("FAIL lu_r0 got=%b exp=00", sel); end
    after_edge();
    total++; if (IDEX_Valid !== 1'b1 || IDEX_WriteReg !== 5'd9) begin bad++; $display("FAIL lu_r0_idex got=%b/%0d exp=1/9", IDEX_Valid, IDEX_WriteReg); end
  endtask

  task automatic test_back_to_back();
    idle2();
    drive(BEQ_M2, 32'h200, 32'd7, 32'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    after_edge();
    drive(JR_5, 32'h204, 32'h400, 32'd0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
    total++; if (sel !== 2'b00 || PCSrc !== 1'b0) begin bad++; $display("FAIL b2b_noreplay got=%b/%b exp=00/0", sel, PCSrc); end
    after_edge();
    total++; if (IDEX_Valid !== 1'b0) begin bad++; $display("FAIL b2b_bubble got=%b exp=0", IDEX_Valid); end
    drive(JR_5, 32'h1FC, 32'h400, 32'd0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
    total++; if (sel !== 2'b01 || jumpTarget !== 32'h1F8) begin bad++; $display("FAIL b2b_run got=%b/%h exp=01/1f8", sel, jumpTarget); end
    after_edge();
  endtask

  task automatic test_reset_mid_squash();
    idle2();
    drive(BEQ_M2, 32'h200, 32'd1, 32'd1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    after_edge();
    @(negedge Clk);
    Instruction_in = ADD_123; PCAddResult_in = 32'h104;
    ReadData1 = 0; ReadData2 = 0;
    Reset = 1'b0;
    #1;
    total++; if (IDEX_Valid !== 1'b0 || IDEX_Instruction !== 32'h0) begin bad++; $display("FAIL rms_clear got=%b/%h exp=0/0", IDEX_Valid, IDEX_Instruction); end
    total++; if (PCSrc !== 1'b0 || sel !== 2'b00) begin bad++; $display("FAIL rms_redirect got=%b/%b exp=0/00", PCSrc, sel); end
    after_edge();
    @(negedge Clk); Reset = 1'b1; #1;
    after_edge();
    total++; if (IDEX_Valid !== 1'b1 || IDEX_WriteReg !== 5'd1 || IDEX_PCAddResult !== 32'h104 || IDEX_Instruction !== ADD_123) begin
      bad++; $display("FAIL rms_release got=%b/%0d/%h/%h exp=1/1/104/%h", IDEX_Valid, IDEX_WriteReg, IDEX_PCAddResult, IDEX_Instruction, ADD_123); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_jr_hazard();
    test_load_use();
    test_back_to_back();
    test_reset_mid_squash();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
